cmp_share_arbiter: RTL

Shares a single 4-bit magnitude comparator among `NUM_REQ` requesters. Each requester presents an operand pair under a valid/ready handshake. A round-robin arbiter grants one requester per cycle and drives its operands through the comparator. The result is registered into a single-entry response slot tagged with the requester index. The block sits between the client blocks and the team's `comparator_4bit` datapath and is the only path to that comparator.

---
 rtl/cmp_share_pkg.sv | 21 ++
 rtl/comparator_4bit.sv | 17 +
 rtl/cmp_share_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/cmp_share_pkg.sv
// rtl/cmp_share_pkg.sv - shared types and flag ordering for the shared comparator path
package cmp_share_pkg;

    localparam int FLAG_GT = 0;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_LT = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // id is sized for the largest legal requester count (8)
    typedef struct packed {
        logic [2:0] id;
        logic       gt;
        logic       eq;
        logic       lt;
    } cmp_rsp_t;

endpackage

// File: rtl/comparator_4bit.sv
// rtl/comparator_4bit.sv - unsigned 4-bit magnitude comparator, flags in package order
module comparator_4bit
    import cmp_share_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [2:0] flags
);

    always_comb begin
        flags          = '0;
        flags[FLAG_GT] = (a > b);
        flags[FLAG_EQ] = (a == b);
        flags[FLAG_LT] = (a < b);
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// rtl/cmp_share_arbiter.sv - round-robin share of one comparator with a single-entry response slot
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_gt,
    output logic                 rsp_eq,
    output logic                 rsp_lt
);

    slot_state_e     state_q, state_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [2:0]      flags_q, flags_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic            load_ok;
    logic            grant;
    logic [3:0]      a_sel;
    logic [3:0]      b_sel;
    logic [2:0]      cmp_flags;

    // Rotate so ptr lands at bit 0, take the lowest set bit, rotate the index back.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [ID_W-1:0]    ptr);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        int                   off;
        int                   idx;
        dbl = {vld, vld} >> ptr;
        rot = dbl[NUM_REQ-1:0];
        off = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        idx = off + int'(ptr);
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        return {|rot, ID_W'(idx)};
    endfunction

    assign a_sel = req_a[{pick_idx, 2'b00} +: 4];
    assign b_sel = req_b[{pick_idx, 2'b00} +: 4];

    comparator_4bit u_cmp (
        .a     (a_sel),
        .b     (b_sel),
        .flags (cmp_flags)
    );

    always_comb begin
        {pick_found, pick_idx} = rr_pick(req_valid, ptr_q);
        load_ok   = (state_q == SLOT_EMPTY) || rsp_ready;
        grant     = pick_found && load_ok && !rst;
        req_ready = grant ? (NUM_REQ'(1) << pick_idx) : '0;

        state_d  = state_q;
        rsp_id_d = rsp_id_q;
        flags_d  = flags_q;
        ptr_d    = ptr_q;
        if (grant) begin
            state_d  = SLOT_FULL;
            rsp_id_d = pick_idx;
            flags_d  = cmp_flags;
            ptr_d    = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end else if (rsp_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SLOT_EMPTY;
            rsp_id_q <= '0;
            flags_q  <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            rsp_id_q <= rsp_id_d;
            flags_q  <= flags_d;
            ptr_q    <= ptr_d;
        end
    end

    assign rsp_valid = (state_q == SLOT_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_gt    = flags_q[FLAG_GT];
    assign rsp_eq    = flags_q[FLAG_EQ];
    assign rsp_lt    = flags_q[FLAG_LT];

endmodule
